// File: rtl/rgb_led_arbiter.sv
// Two-requester fixed-priority owner of the active-low RGB LED, with a minimum
// grant hold time and per-channel PWM whose duty is reloaded only at period start.
module rgb_led_arbiter #(
  parameter int PWM_BITS    = 8,
  parameter int HOLD_CYCLES = 1200000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [3*PWM_BITS-1:0]   colour0,
  input  logic [3*PWM_BITS-1:0]   colour1,
  output logic [1:0]              gnt,
  output logic                    led_r,
  output logic                    led_g,
  output logic                    led_b
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_gnt;
  logic [HW-1:0]         r_hold;
  logic                  w_hold_done;
  logic [PWM_BITS-1:0]   r_pwm;
  logic                  w_wrap;
  logic [3*PWM_BITS-1:0] w_owner_colour;
  logic [PWM_BITS-1:0]   r_duty [3];
  logic [2:0]            r_led;

  assign w_hold_done = (r_hold == HW'(HOLD_CYCLES));
  assign w_wrap      = (r_pwm == {PWM_BITS{1'b1}});

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req[0])      w_state_next = S_OWN0;
        else if (req[1]) w_state_next = S_OWN1;
      end
      S_OWN0: begin
        if (w_hold_done && !req[0])
          w_state_next = req[1] ? S_OWN1 : S_IDLE;
      end
      S_OWN1: begin
        // Low-priority owner is only pre-empted once its hold has elapsed.
        if (w_hold_done) begin
          if (req[0])       w_state_next = S_OWN0;
          else if (!req[1]) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= {w_state_next == S_OWN1, w_state_next == S_OWN0};
      if (w_state_next != r_state)
        r_hold <= '0;
      else if (r_state != S_IDLE && !w_hold_done)
        r_hold <= r_hold + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm <= '0;
    else     r_pwm <= r_pwm + PWM_BITS'(1);
  end

  always_comb begin
    w_owner_colour = '0;
    if (r_state == S_OWN0)      w_owner_colour = colour0;
    else if (r_state == S_OWN1) w_owner_colour = colour1;
  end

  // Channel gi: 0 = blue (LSBs), 1 = green, 2 = red (MSBs).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_duty[gi] <= '0;
          r_led[gi]  <= 1'b1;
        end else begin
          if (w_wrap)
            r_duty[gi] <= w_owner_colour[gi*PWM_BITS +: PWM_BITS];
          r_led[gi] <= ~(r_pwm < r_duty[gi]);
        end
      end
    end
  endgenerate

  assign gnt   = r_gnt;
  assign led_r = r_led[2];
  assign led_g = r_led[1];
  assign led_b = r_led[0];

endmodule
